// File: rtl/aer_rx_pkg.sv
// Shared constants for the AER output receiver: Wishbone register map,
// CTRL/STATUS bit positions, handshake FSM states and event entry sizing.
package aer_rx_pkg;

    localparam logic [1:0] ADR_EVT     = 2'd0;
    localparam logic [1:0] ADR_STATUS  = 2'd1;
    localparam logic [1:0] ADR_CTRL    = 2'd2;
    localparam logic [1:0] ADR_DROPCNT = 2'd3;

    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_DROP_BIT    = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT  = 2;
    localparam int unsigned CTRL_THR_LSB     = 8;
    localparam int unsigned CTRL_THR_W       = 5;
    localparam int unsigned CTRL_OVF_CLR_BIT = 31;

    localparam int unsigned ST_CNT_W      = 5;
    localparam int unsigned ST_EMPTY_BIT  = 8;
    localparam int unsigned ST_FULL_BIT   = 9;
    localparam int unsigned ST_OVF_BIT    = 10;
    localparam int unsigned EVT_VALID_BIT = 31;

    localparam int unsigned DROPCNT_W = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACK_HI = 1'b1
    } rx_state_e;

    // FIFO entry layout is {timestamp, address}.
    function automatic int unsigned entry_width(input int unsigned ts_w, input int unsigned data_w);
        return ts_w + data_w;
    endfunction

endpackage

// File: rtl/aer_evt_fifo.sv
// Single-clock event FIFO; pointers carry an extra MSB so full and empty
// are distinguished without a separate occupancy register.
module aer_evt_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    always_comb begin
        count   = wptr_q - rptr_q;
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
        rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
        rdata   = mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/aer_out_receiver.sv
// Consumer end of the core's output AER link: 4-phase handshake, event
// timestamping into a FIFO, and a Wishbone slave for draining and control.
module aer_out_receiver
    import aer_rx_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned TS_W        = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              OUT_REQ,
    input  logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_ACK,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              irq
);
    localparam int unsigned ENTRY_W = entry_width(TS_W, DATA_W);
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    rx_state_e              state_q, state_d;
    logic                   ack_q, ack_d;
    logic [TS_W-1:0]        ts_q, ts_d;
    logic                   en_q, en_d, drop_q, drop_d, irq_en_q, irq_en_d;
    logic [CTRL_THR_W-1:0]  thr_q, thr_d;
    logic                   ovf_q, ovf_d;
    logic [DROPCNT_W-1:0]   dropcnt_q, dropcnt_d;
    logic                   wb_ack_q, wb_ack_d;
    logic [31:0]            wb_dat_q, wb_dat_d;
    logic                   irq_q, irq_d;

    logic                   req_s, drop_evt, ovf_clr, cnt_clr, wb_fire;
    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic [ENTRY_W-1:0]     fifo_rdata;
    logic [1:0]             wb_adr;
    logic [31:0]            evt_word, status_word, ctrl_word;
    logic [CTRL_THR_W-1:0]  thr_eff;
    logic                   unused_wb;

    assign unused_wb = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0],
                         wbs_dat_i[30:13], wbs_dat_i[7:3]};

    aer_evt_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RSTN),
        .push  (fifo_push),
        .wdata ({ts_q, OUT_DATA}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], OUT_REQ};
        req_s  = sync_q[SYNC_STAGES-1];
        ts_d   = ts_q + 1'b1;

        state_d   = state_q;
        ack_d     = ack_q;
        fifo_push = 1'b0;
        drop_evt  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_s && en_q) begin
                    if (!fifo_full) begin
                        fifo_push = 1'b1;
                        state_d   = ACK_HI;
                        ack_d     = 1'b1;
                    end else if (drop_q) begin
                        drop_evt = 1'b1;
                        state_d  = ACK_HI;
                        ack_d    = 1'b1;
                    end
                end
            end
            ACK_HI: begin
                if (!req_s) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end
            end
        endcase

        thr_eff = (thr_q == '0) ? CTRL_THR_W'(1) : thr_q;

        evt_word                 = '0;
        evt_word[EVT_VALID_BIT]  = 1'b1;
        evt_word[ENTRY_W-1:0]    = fifo_rdata;

        status_word                = '0;
        status_word[ST_CNT_W-1:0]  = ST_CNT_W'(fifo_count);
        status_word[ST_EMPTY_BIT]  = fifo_empty;
        status_word[ST_FULL_BIT]   = fifo_full;
        status_word[ST_OVF_BIT]    = ovf_q;

        ctrl_word                                = '0;
        ctrl_word[CTRL_EN_BIT]                   = en_q;
        ctrl_word[CTRL_DROP_BIT]                 = drop_q;
        ctrl_word[CTRL_IRQ_EN_BIT]               = irq_en_q;
        ctrl_word[CTRL_THR_LSB +: CTRL_THR_W]    = thr_q;

        wb_adr   = wbs_adr_i[3:2];
        wb_fire  = wbs_cyc_i & wbs_stb_i & ~wb_ack_q;
        wb_ack_d = wb_fire;
        wb_dat_d = '0;
        fifo_pop = 1'b0;
        ovf_clr  = 1'b0;
        cnt_clr  = 1'b0;
        en_d     = en_q;
        drop_d   = drop_q;
        irq_en_d = irq_en_q;
        thr_d    = thr_q;

        if (wb_fire && wbs_we_i) begin
            unique case (wb_adr)
                ADR_CTRL: begin
                    en_d     = wbs_dat_i[CTRL_EN_BIT];
                    drop_d   = wbs_dat_i[CTRL_DROP_BIT];
                    irq_en_d = wbs_dat_i[CTRL_IRQ_EN_BIT];
                    thr_d    = wbs_dat_i[CTRL_THR_LSB +: CTRL_THR_W];
                    ovf_clr  = wbs_dat_i[CTRL_OVF_CLR_BIT];
                end
                ADR_DROPCNT: cnt_clr = 1'b1;
                default: ;
            endcase
        end else if (wb_fire) begin
            unique case (wb_adr)
                ADR_EVT: begin
                    if (!fifo_empty) begin
                        wb_dat_d = evt_word;
                        fifo_pop = 1'b1;
                    end
                end
                ADR_STATUS:  wb_dat_d = status_word;
                ADR_CTRL:    wb_dat_d = ctrl_word;
                ADR_DROPCNT: wb_dat_d = 32'(dropcnt_q);
            endcase
        end

        // A drop landing in the same cycle as a clear wins: that event did overflow.
        ovf_d = (ovf_q & ~ovf_clr) | drop_evt;
        if (cnt_clr) begin
            dropcnt_d = '0;
        end else if (drop_evt && (dropcnt_q != '1)) begin
            dropcnt_d = dropcnt_q + 1'b1;
        end else begin
            dropcnt_d = dropcnt_q;
        end

        irq_d = irq_en_q & ((32'(fifo_count) >= 32'(thr_eff)) | ovf_q);
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            sync_q    <= '0;
            state_q   <= IDLE;
            ack_q     <= 1'b0;
            ts_q      <= '0;
            en_q      <= 1'b0;
            drop_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            thr_q     <= '0;
            ovf_q     <= 1'b0;
            dropcnt_q <= '0;
            wb_ack_q  <= 1'b0;
            wb_dat_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            ack_q     <= ack_d;
            ts_q      <= ts_d;
            en_q      <= en_d;
            drop_q    <= drop_d;
            irq_en_q  <= irq_en_d;
            thr_q     <= thr_d;
            ovf_q     <= ovf_d;
            dropcnt_q <= dropcnt_d;
            wb_ack_q  <= wb_ack_d;
            wb_dat_q  <= wb_dat_d;
            irq_q     <= irq_d;
        end
    end

    assign OUT_ACK   = ack_q;
    assign wbs_ack_o = wb_ack_q;
    assign wbs_dat_o = wb_dat_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_aer_out_receiver.sv
// Directed bench for aer_out_receiver: handshake, enable gating, back-pressure,
// drop/overflow, interrupt threshold and reset mid-handshake.
`timescale 1ns/1ps
module tb_aer_out_receiver;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        OUT_REQ = 1'b0;
    logic [7:0]  OUT_DATA = '0;
    logic        OUT_ACK;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'hF;
    logic [31:0] wbs_adr_i = '0;
    logic [31:0] wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        irq;

    int checks = 0;
    int failures = 0;

    // Reference time base: cycles since the last reset edge.
    logic [15:0] tb_ts;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (!RSTN) tb_ts <= '0;
        else       tb_ts <= tb_ts + 16'd1;
    end

    aer_out_receiver #(
        .DATA_W      (8),
        .DEPTH       (16),
        .TS_W        (16),
        .SYNC_STAGES (2)
    ) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .OUT_REQ   (OUT_REQ),
        .OUT_DATA  (OUT_DATA),
        .OUT_ACK   (OUT_ACK),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .irq       (irq)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [1:0] a, input logic [31:0] wd,
                           output logic [31:0] rd);
        logic got;
        got = 1'b0;
        rd  = '0;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = {28'd0, a, 2'b00};
        wbs_dat_i = wd;
        for (int i = 0; i < 4 && !got; i++) begin
            tick();
            if (wbs_ack_o) begin
                got = 1'b1;
                rd  = wbs_dat_o;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        check_eq("wb_ack", 32'(got), 32'd1);
        tick();
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] rd);
        wb_xfer(1'b0, a, 32'd0, rd);
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] dummy;
        wb_xfer(1'b1, a, wd, dummy);
    endtask

    task automatic raise_req(input logic [7:0] d);
        OUT_DATA = d;
        OUT_REQ  = 1'b1;
    endtask

    task automatic wait_ack(input int max_cyc, output logic acked, output logic [15:0] cap_ts,
                            output int lat);
        logic [15:0] prev;
        acked  = 1'b0;
        cap_ts = '0;
        lat    = 0;
        for (int i = 0; i < max_cyc && !acked; i++) begin
            prev = tb_ts;
            tick();
            lat = i + 1;
            if (OUT_ACK) begin
                acked  = 1'b1;
                cap_ts = prev;
            end
        end
    endtask

    task automatic release_req();
        int n;
        OUT_REQ = 1'b0;
        n = 0;
        while (OUT_ACK && n < 10) begin
            tick();
            n++;
        end
        check_eq("ack_fall", 32'(OUT_ACK), 32'd0);
    endtask

    task automatic send(input logic [7:0] d, output logic acked);
        logic [15:0] ts;
        int lat;
        raise_req(d);
        wait_ack(12, acked, ts, lat);
        if (acked) release_req();
        else       OUT_REQ = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        acked;
        logic [15:0] ts;
        int          lat;
        int          nack;

        // Reset values
        RSTN = 1'b0;
        repeat (3) tick();
        check_eq("rst_out_ack", 32'(OUT_ACK), 32'd0);
        check_eq("rst_wb_ack", 32'(wbs_ack_o), 32'd0);
        check_eq("rst_wb_dat", wbs_dat_o, 32'd0);
        check_eq("rst_irq", 32'(irq), 32'd0);
        RSTN = 1'b1;
        tick();
        wb_read(2'd1, rd);
        check_eq("rst_status", rd, 32'h0000_0100);

        // Single event: latency, timestamp, pop, empty read
        wb_write(2'd2, 32'h1);
        raise_req(8'h5A);
        wait_ack(12, acked, ts, lat);
        check_eq("ev1_acked", 32'(acked), 32'd1);
        check_eq("ev1_latency", 32'(lat), 32'd3);
        release_req();
        wb_read(2'd0, rd);
        check_eq("ev1_evt", rd, {8'h80, ts, 8'h5A});
        wb_read(2'd0, rd);
        check_eq("ev1_empty_evt", rd, 32'd0);

        // Disabled: no ACK; enabling completes the handshake
        wb_write(2'd2, 32'h0);
        raise_req(8'h33);
        nack = 0;
        repeat (50) begin
            tick();
            if (OUT_ACK) nack++;
        end
        check_eq("dis_noack", 32'(nack), 32'd0);
        wb_write(2'd2, 32'h1);
        wait_ack(12, acked, ts, lat);
        check_eq("en_acked", 32'(acked), 32'd1);
        release_req();
        wb_read(2'd1, rd);
        check_eq("en_status", rd, 32'h0000_0001);
        wb_read(2'd0, rd);
        check_eq("en_evt", rd & 32'h8000_00FF, 32'h8000_0033);

        // Back-pressure with drop=0
        nack = 0;
        for (int i = 0; i < 16; i++) begin
            send(8'(8'h10 + i), acked);
            if (acked) nack++;
        end
        check_eq("bp_acks", 32'(nack), 32'd16);
        wb_read(2'd1, rd);
        check_eq("bp_full", rd, 32'h0000_0210);
        raise_req(8'h20);
        wait_ack(20, acked, ts, lat);
        check_eq("bp_stall", 32'(acked), 32'd0);
        wb_read(2'd0, rd);
        check_eq("bp_pop", rd & 32'h8000_00FF, 32'h8000_0010);
        wait_ack(12, acked, ts, lat);
        check_eq("bp_resume", 32'(acked), 32'd1);
        release_req();
        wb_read(2'd1, rd);
        check_eq("bp_full2", rd, 32'h0000_0210);
        for (int i = 0; i < 16; i++) begin
            wb_read(2'd0, rd);
            check_eq("bp_drain", rd & 32'h8000_00FF, 32'h8000_0000 | 32'(8'h11 + i));
        end
        wb_read(2'd1, rd);
        check_eq("bp_empty", rd, 32'h0000_0100);

        // Drop mode: overflow and drop counter
        wb_write(2'd2, 32'h3);
        nack = 0;
        for (int i = 0; i < 20; i++) begin
            send(8'(8'h40 + i), acked);
            if (acked) nack++;
        end
        check_eq("dr_acks", 32'(nack), 32'd20);
        wb_read(2'd3, rd);
        check_eq("dr_dropcnt", rd, 32'd4);
        wb_read(2'd1, rd);
        check_eq("dr_status_ovf", rd, 32'h0000_0610);
        wb_write(2'd2, 32'h8000_0003);
        wb_read(2'd1, rd);
        check_eq("dr_ovf_clr", rd, 32'h0000_0210);
        wb_read(2'd2, rd);
        check_eq("dr_ctrl_rb", rd, 32'h0000_0003);
        wb_write(2'd3, 32'h0000_1234);
        wb_read(2'd3, rd);
        check_eq("dr_cnt_clr", rd, 32'd0);
        wb_read(2'd0, rd);
        check_eq("dr_first", rd & 32'h8000_00FF, 32'h8000_0040);
        for (int i = 0; i < 15; i++) wb_read(2'd0, rd);
        wb_read(2'd1, rd);
        check_eq("dr_empty", rd, 32'h0000_0100);

        // Interrupt threshold
        wb_write(2'd2, 32'h0000_0305);
        check_eq("irq_idle", 32'(irq), 32'd0);
        send(8'h61, acked);
        send(8'h62, acked);
        repeat (2) tick();
        check_eq("irq_cnt2", 32'(irq), 32'd0);
        send(8'h63, acked);
        repeat (2) tick();
        check_eq("irq_cnt3", 32'(irq), 32'd1);
        wb_read(2'd0, rd);
        check_eq("irq_after_pop", 32'(irq), 32'd0);
        wb_read(2'd0, rd);
        check_eq("irq_cnt1_thr3", 32'(irq), 32'd0);
        wb_write(2'd2, 32'h0000_0005);
        check_eq("irq_thr0", 32'(irq), 32'd1);
        wb_read(2'd1, rd);
        check_eq("irq_status", rd, 32'h0000_0001);

        // Reset in ACK_HI with 5 entries
        for (int i = 0; i < 3; i++) send(8'(8'h70 + i), acked);
        wb_read(2'd1, rd);
        check_eq("rr_status4", rd, 32'h0000_0004);
        raise_req(8'h7F);
        wait_ack(12, acked, ts, lat);
        check_eq("rr_in_ackhi", 32'(acked), 32'd1);
        RSTN    = 1'b0;
        OUT_REQ = 1'b0;
        tick();
        check_eq("rr_ack_drop", 32'(OUT_ACK), 32'd0);
        check_eq("rr_irq", 32'(irq), 32'd0);
        RSTN = 1'b1;
        wb_read(2'd1, rd);
        check_eq("rr_status", rd, 32'h0000_0100);
        wb_read(2'd2, rd);
        check_eq("rr_ctrl", rd, 32'd0);
        wb_write(2'd2, 32'h1);
        raise_req(8'h5C);
        wait_ack(12, acked, ts, lat);
        release_req();
        wb_read(2'd0, rd);
        check_eq("rr_ts_restart", rd, 32'h8000_085C);
        wb_read(2'd3, rd);
        check_eq("rr_dropcnt", rd, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
